// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-side memory responder:
// memory-stage request bundles, size codes and FSM states.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        logic [1:0]  size;
    } m_r_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] wd;
    } m_w_t;

    typedef enum logic [2:0] {
        DM_IDLE,
        DM_ADDR,
        DM_DATA,
        DM_DONE,
        DM_CANCEL
    } dmem_state_t;

    // Zero the byte lanes the store does not own.
    function automatic logic [31:0] lane_mask(input logic [3:0] strobe);
        return {{8{strobe[3]}}, {8{strobe[2]}},
                {8{strobe[1]}}, {8{strobe[0]}}};
    endfunction

endpackage

// File: rtl/dmem_responder.sv
// Data-side memory responder: one bus transaction per
// memory-stage access, result held until the stage advances.
module dmem_responder
    import dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  m_r_t        mread,
    input  m_w_t        mwrite,
    input  logic        flush,
    input  logic        advance,
    output logic [31:0] rd,
    output logic        d_data_ok,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    dmem_state_t state, state_nxt;
    logic        act;
    logic        rd_load;

    assign act        = mwrite.wen | mread.ren;
    assign data_wr    = mwrite.wen;
    assign data_addr  = mwrite.wen ? mwrite.addr : mread.addr;
    assign data_size  = mwrite.wen ? mwrite.size : mread.size;
    assign data_wdata = mwrite.wd & lane_mask(mwrite.strobe);
    assign d_data_ok  = (state == DM_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DM_IDLE;
            rd    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (rd_load)
                rd <= data_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        data_req  = 1'b0;
        rd_load   = 1'b0;
        unique case (state)
            DM_IDLE: begin
                data_req = act & ~flush;
                if (data_req) begin
                    if (data_addr_ok) begin
                        state_nxt = data_data_ok ? DM_DONE : DM_DATA;
                        rd_load   = data_data_ok & ~data_wr;
                    end else begin
                        state_nxt = DM_ADDR;
                    end
                end
            end
            DM_ADDR: begin
                data_req = 1'b1;
                if (flush) begin
                    // An accept racing the flush still owes a data phase.
                    if (data_addr_ok && !data_data_ok)
                        state_nxt = DM_CANCEL;
                    else
                        state_nxt = DM_IDLE;
                end else if (data_addr_ok) begin
                    state_nxt = data_data_ok ? DM_DONE : DM_DATA;
                    rd_load   = data_data_ok & ~data_wr;
                end
            end
            DM_DATA: begin
                if (data_data_ok) begin
                    state_nxt = flush ? DM_IDLE : DM_DONE;
                    rd_load   = ~flush & ~data_wr;
                end else if (flush) begin
                    state_nxt = DM_CANCEL;
                end
            end
            DM_DONE: begin
                if (advance || flush)
                    state_nxt = DM_IDLE;
            end
            DM_CANCEL: begin
                if (data_data_ok)
                    state_nxt = DM_IDLE;
            end
            default: state_nxt = DM_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        resetn;
    m_r_t        mread;
    m_w_t        mwrite;
    logic        flush;
    logic        advance;
    logic [31:0] rd;
    logic        d_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;

    dmem_responder dut (
        .clk(clk), .resetn(resetn),
        .mread(mread), .mwrite(mwrite),
        .flush(flush), .advance(advance),
        .rd(rd), .d_data_ok(d_data_ok),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        mread        = '0;
        mwrite       = '0;
        flush        = 1'b0;
        advance      = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #12;
        chk("rst_rd", rd, 32'h0);
        chk("rst_dok", {31'b0, d_data_ok}, 32'h0);
        chk("rst_req", {31'b0, data_req}, 32'h0);
        step();
        resetn = 1'b1;
        step();

        // Zero-wait word read
        mread.ren    = 1'b1;
        mread.addr   = 32'h8000_0010;
        mread.size   = SZ_WORD;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        settle();
        chk("rd0_req", {31'b0, data_req}, 32'h1);
        chk("rd0_wr", {31'b0, data_wr}, 32'h0);
        chk("rd0_addr", data_addr, 32'h8000_0010);
        chk("rd0_size", {30'b0, data_size}, 32'h2);
        chk("rd0_dok_c0", {31'b0, d_data_ok}, 32'h0);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        settle();
        chk("rd0_dok_c1", {31'b0, d_data_ok}, 32'h1);
        chk("rd0_rd", rd, 32'hDEAD_BEEF);
        chk("rd0_req_c1", {31'b0, data_req}, 32'h0);

        // Stall in DONE for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_dok", {31'b0, d_data_ok}, 32'h1);
            chk("hold_req", {31'b0, data_req}, 32'h0);
        end
        advance = 1'b1;
        step();
        advance   = 1'b0;
        mread.ren = 1'b0;
        settle();
        chk("rd0_idle_dok", {31'b0, d_data_ok}, 32'h0);

        // Byte write, addr_ok after 3 waits, data_ok 2 later
        mwrite.wen    = 1'b1;
        mwrite.addr   = 32'h0000_1002;
        mwrite.size   = SZ_BYTE;
        mwrite.strobe = 4'b0100;
        mwrite.wd     = 32'h00AA_0000;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            settle();
            chk("wb_req", {31'b0, data_req}, 32'h1);
            chk("wb_size", {30'b0, data_size}, 32'h0);
            chk("wb_wr", {31'b0, data_wr}, 32'h1);
            chk("wb_wdata", data_wdata, 32'h00AA_0000);
            chk("wb_dok", {31'b0, d_data_ok}, 32'h0);
            step();
        end
        data_addr_ok = 1'b0;
        settle();
        chk("wb_data_req", {31'b0, data_req}, 32'h0);
        chk("wb_data_dok", {31'b0, d_data_ok}, 32'h0);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        settle();
        chk("wb_dok_pre", {31'b0, d_data_ok}, 32'h0);
        step();
        data_data_ok = 1'b0;
        settle();
        chk("wb_dok", {31'b0, d_data_ok}, 32'h1);
        chk("wb_rd_keep", rd, 32'hDEAD_BEEF);
        advance = 1'b1;
        step();
        advance    = 1'b0;
        mwrite.wen = 1'b0;

        // Flush while in DATA
        mread.ren    = 1'b1;
        mread.addr   = 32'h0000_0100;
        mread.size   = SZ_WORD;
        data_addr_ok = 1'b1;
        settle();
        chk("fd_req", {31'b0, data_req}, 32'h1);
        step();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        settle();
        chk("fd_dok0", {31'b0, d_data_ok}, 32'h0);
        step();
        flush     = 1'b0;
        mread.ren = 1'b0;
        settle();
        chk("fd_cancel_dok", {31'b0, d_data_ok}, 32'h0);
        chk("fd_cancel_req", {31'b0, data_req}, 32'h0);
        step();
        mread.ren    = 1'b1;
        mread.addr   = 32'h0000_0200;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000_1234;
        settle();
        chk("fd_cancel_req2", {31'b0, data_req}, 32'h0);
        chk("fd_cancel_dok2", {31'b0, d_data_ok}, 32'h0);
        step();
        data_data_ok = 1'b0;
        settle();
        chk("fd_rd_keep", rd, 32'hDEAD_BEEF);
        chk("fd_dok_idle", {31'b0, d_data_ok}, 32'h0);
        chk("fd_new_req", {31'b0, data_req}, 32'h1);
        chk("fd_new_addr", data_addr, 32'h0000_0200);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_0001;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        settle();
        chk("fd_new_dok", {31'b0, d_data_ok}, 32'h1);
        chk("fd_new_rd", rd, 32'hCAFE_0001);
        advance = 1'b1;
        step();
        advance   = 1'b0;
        mread.ren = 1'b0;

        // Flush while in ADDR
        mread.ren  = 1'b1;
        mread.addr = 32'h0000_0300;
        settle();
        chk("fa_req_c0", {31'b0, data_req}, 32'h1);
        step();
        flush = 1'b1;
        settle();
        chk("fa_req_addr", {31'b0, data_req}, 32'h1);
        step();
        flush     = 1'b0;
        mread.ren = 1'b0;
        settle();
        chk("fa_req_drop", {31'b0, data_req}, 32'h0);
        chk("fa_dok", {31'b0, d_data_ok}, 32'h0);
        step();
        chk("fa_dok2", {31'b0, d_data_ok}, 32'h0);

        // Read and write together: write wins
        mread.ren     = 1'b1;
        mread.addr    = 32'h0000_0400;
        mread.size    = SZ_HALF;
        mwrite.wen    = 1'b1;
        mwrite.addr   = 32'h0000_0500;
        mwrite.size   = SZ_WORD;
        mwrite.strobe = 4'b1111;
        mwrite.wd     = 32'h1357_9BDF;
        data_addr_ok  = 1'b1;
        data_data_ok  = 1'b1;
        data_rdata    = 32'h0000_0099;
        settle();
        chk("rw_wr", {31'b0, data_wr}, 32'h1);
        chk("rw_addr", data_addr, 32'h0000_0500);
        chk("rw_size", {30'b0, data_size}, 32'h2);
        chk("rw_wdata", data_wdata, 32'h1357_9BDF);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        settle();
        chk("rw_dok", {31'b0, d_data_ok}, 32'h1);
        chk("rw_rd_keep", rd, 32'hCAFE_0001);
        chk("rw_req_done", {31'b0, data_req}, 32'h0);
        advance = 1'b1;
        step();
        advance    = 1'b0;
        mread.ren  = 1'b0;
        mwrite.wen = 1'b0;

        // Reset mid-transaction
        mread.ren    = 1'b1;
        mread.addr   = 32'h0000_0600;
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        mread.ren    = 1'b0;
        resetn       = 1'b0;
        settle();
        chk("mr_rd", rd, 32'h0);
        chk("mr_dok", {31'b0, d_data_ok}, 32'h0);
        chk("mr_req", {31'b0, data_req}, 32'h0);
        step();
        resetn       = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        step();
        data_data_ok = 1'b0;
        settle();
        chk("mr_idle_dok", {31'b0, d_data_ok}, 32'h0);
        chk("mr_idle_rd", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
